// File: rtl/timer_counter.sv
// Timer count/compare stage.
// Holds a free-running 64-bit count and a 64-bit compare value. Both are
// written 32 bits at a time. A count/compare match sets a sticky status bit.
// That status bit, gated by an enable, drives the timer interrupt.
module timer_counter #(
  parameter int CNT_W  = 64,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cnt_en,
  input  logic              wr_en,
  input  logic [2:0]        wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  output logic [CNT_W-1:0]  cnt_val,
  output logic [CNT_W-1:0]  cmp_val,
  output logic              int_st,
  output logic              int_en,
  output logic              tim_int
);

  localparam logic [2:0] SEL_CNT_LO = 3'd0;
  localparam logic [2:0] SEL_CNT_HI = 3'd1;
  localparam logic [2:0] SEL_CMP_LO = 3'd2;
  localparam logic [2:0] SEL_CMP_HI = 3'd3;
  localparam logic [2:0] SEL_INT_ST = 3'd4;
  localparam logic [2:0] SEL_INT_EN = 3'd5;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cmp_q;
  logic             int_st_q;
  logic             int_en_q;

  logic wr_cnt_lo;
  logic wr_cnt_hi;
  logic wr_cmp_lo;
  logic wr_cmp_hi;
  logic wr_st_clr;
  logic wr_int_en;
  logic match;

  assign wr_cnt_lo = wr_en && (wr_sel == SEL_CNT_LO);
  assign wr_cnt_hi = wr_en && (wr_sel == SEL_CNT_HI);
  assign wr_cmp_lo = wr_en && (wr_sel == SEL_CMP_LO);
  assign wr_cmp_hi = wr_en && (wr_sel == SEL_CMP_HI);
  assign wr_st_clr = wr_en && (wr_sel == SEL_INT_ST) && wr_data[0];
  assign wr_int_en = wr_en && (wr_sel == SEL_INT_EN);

  // Compare on registered values only, so the status rises one cycle after the count reaches the compare value.
  assign match = (cnt_q == cmp_q);

  // Counter: a software write takes priority and swallows a coincident increment pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (wr_cnt_lo) begin
      cnt_q[DATA_W-1:0] <= wr_data;
    end else if (wr_cnt_hi) begin
      cnt_q[CNT_W-1:DATA_W] <= wr_data;
    end else if (cnt_en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Compare register: each half is written independently.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_q <= '1;
    end else if (wr_cmp_lo) begin
      cmp_q[DATA_W-1:0] <= wr_data;
    end else if (wr_cmp_hi) begin
      cmp_q[CNT_W-1:DATA_W] <= wr_data;
    end
  end

  // Sticky status: a match set wins over a write-one-to-clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_st_q <= 1'b0;
    end else if (match) begin
      int_st_q <= 1'b1;
    end else if (wr_st_clr) begin
      int_st_q <= 1'b0;
    end
  end

  // Interrupt enable: only bit 0 of the write data is meaningful.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_en_q <= 1'b0;
    end else if (wr_int_en) begin
      int_en_q <= wr_data[0];
    end
  end

  assign cnt_val = cnt_q;
  assign cmp_val = cmp_q;
  assign int_st  = int_st_q;
  assign int_en  = int_en_q;
  // Both inputs are flops, so the AND cannot glitch.
  assign tim_int = int_st_q & int_en_q;

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter.
// The stimulus drives one cycle at a time and queues the state it expects
// after that edge. The monitor pops the queue on the falling edge and
// compares the DUT outputs against each queued entry.
module tb_timer_counter;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        rst;
  logic        cnt_en;
  logic        wr_en;
  logic [2:0]  wr_sel;
  logic [31:0] wr_data;
  logic [63:0] cnt_val;
  logic [63:0] cmp_val;
  logic        int_st;
  logic        int_en;
  logic        tim_int;

  typedef struct {
    string       name;
    logic [63:0] cnt;
    logic [63:0] cmp;
    logic        st;
    logic        en;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  timer_counter dut (
    .clk     (clk),
    .rst     (rst),
    .cnt_en  (cnt_en),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_data (wr_data),
    .cnt_val (cnt_val),
    .cmp_val (cmp_val),
    .int_st  (int_st),
    .int_en  (int_en),
    .tim_int (tim_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input string field,
                       input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s.%s: got %h expected %h", name, field, act, expv);
    end
  endtask

  // Monitor: compare every queued expectation against the settled outputs.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.name, "cnt_val", cnt_val, e.cnt);
      check(e.name, "cmp_val", cmp_val, e.cmp);
      check(e.name, "int_st", {63'd0, int_st}, {63'd0, e.st});
      check(e.name, "int_en", {63'd0, int_en}, {63'd0, e.en});
      check(e.name, "tim_int", {63'd0, tim_int}, {63'd0, e.st & e.en});
    end
  end

  // Drive one cycle of inputs, then queue the expected post-edge state.
  task automatic cyc(input logic r, input logic ce, input logic we,
                     input logic [2:0] sel, input logic [31:0] data,
                     input string name, input logic [63:0] e_cnt,
                     input logic [63:0] e_cmp, input logic e_st, input logic e_en);
    exp_t e;
    rst     = r;
    cnt_en  = ce;
    wr_en   = we;
    wr_sel  = sel;
    wr_data = data;
    @(posedge clk);
    #1;
    e.name = name;
    e.cnt  = e_cnt;
    e.cmp  = e_cmp;
    e.st   = e_st;
    e.en   = e_en;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cnt_en = 1'b0; wr_en = 1'b0; wr_sel = 3'd0; wr_data = 32'd0;
    @(negedge clk);
    // Reset overrides a coincident count pulse and write
    cyc(1, 1, 1, 3'd0, 32'd55, "reset", 64'd0, ONES, 0, 0);

    // Five pulses with gaps
    cyc(0, 1, 0, 3'd0, 32'd0, "cnt1",   64'd1, ONES, 0, 0);
    cyc(0, 0, 0, 3'd0, 32'd0, "hold1",  64'd1, ONES, 0, 0);
    cyc(0, 1, 0, 3'd0, 32'd0, "cnt2",   64'd2, ONES, 0, 0);
    cyc(0, 1, 0, 3'd0, 32'd0, "cnt3",   64'd3, ONES, 0, 0);
    cyc(0, 0, 0, 3'd0, 32'd0, "hold3",  64'd3, ONES, 0, 0);
    cyc(0, 1, 0, 3'd0, 32'd0, "cnt4",   64'd4, ONES, 0, 0);
    cyc(0, 0, 0, 3'd0, 32'd0, "hold4",  64'd4, ONES, 0, 0);
    cyc(0, 1, 0, 3'd0, 32'd0, "cnt5",   64'd5, ONES, 0, 0);

    // Ignored writes
    cyc(0, 0, 1, 3'd6, 32'hFFFF_FFFF, "sel6",   64'd5, ONES, 0, 0);
    cyc(0, 0, 1, 3'd7, 32'hFFFF_FFFF, "sel7",   64'd5, ONES, 0, 0);
    cyc(0, 0, 0, 3'd0, 32'd77,        "no_wen", 64'd5, ONES, 0, 0);

    // Carry from the low half into the high half
    cyc(0, 1, 1, 3'd0, 32'hFFFF_FFFF, "wr_lo_ff", 64'h0000_0000_FFFF_FFFF, ONES, 0, 0);
    cyc(0, 0, 1, 3'd1, 32'd0,         "wr_hi_0",  64'h0000_0000_FFFF_FFFF, ONES, 0, 0);
    cyc(0, 1, 0, 3'd0, 32'd0,         "carry",    64'h0000_0001_0000_0000, ONES, 0, 0);

    // Wrap at all-ones with compare = 5: no status
    cyc(0, 0, 1, 3'd2, 32'd5, "cmp_lo5", 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_0000_0005, 0, 0);
    cyc(0, 0, 1, 3'd3, 32'd0, "cmp_hi0", 64'h0000_0001_0000_0000, 64'd5, 0, 0);
    cyc(0, 0, 1, 3'd0, 32'hFFFF_FFFF, "wr_lo_ff2", 64'h0000_0001_FFFF_FFFF, 64'd5, 0, 0);
    cyc(0, 0, 1, 3'd1, 32'hFFFF_FFFF, "wr_hi_ff",  ONES, 64'd5, 0, 0);
    cyc(0, 1, 0, 3'd0, 32'd0, "wrap",      64'd0, 64'd5, 0, 0);
    cyc(0, 0, 0, 3'd0, 32'd0, "wrap_hold", 64'd0, 64'd5, 0, 0);

    // Wrap with compare = 0: status rises one cycle after reaching 0
    cyc(0, 0, 1, 3'd0, 32'hFFFF_FFFF, "wr_lo_ff3", 64'h0000_0000_FFFF_FFFF, 64'd5, 0, 0);
    cyc(0, 0, 1, 3'd1, 32'hFFFF_FFFF, "wr_hi_ff2", ONES, 64'd5, 0, 0);
    cyc(0, 0, 1, 3'd2, 32'd0, "cmp_lo0",   ONES, 64'd0, 0, 0);
    cyc(0, 1, 0, 3'd0, 32'd0, "wrap0",     64'd0, 64'd0, 0, 0);
    cyc(0, 0, 0, 3'd0, 32'd0, "wrap0_st",  64'd0, 64'd0, 1, 0);

    // Move the compare value away, clear status, then set the enable
    cyc(0, 0, 1, 3'd2, 32'd10, "cmp_lo10", 64'd0, 64'd10, 1, 0);
    cyc(0, 0, 1, 3'd4, 32'd1,  "clr0",     64'd0, 64'd10, 0, 0);
    cyc(0, 0, 1, 3'd5, 32'hFFFF_FFFE, "en_bit0_0", 64'd0, 64'd10, 0, 0);
    cyc(0, 0, 1, 3'd5, 32'd1,  "en_1",     64'd0, 64'd10, 0, 1);

    // Count to the compare value: status and interrupt one cycle later
    for (int i = 1; i <= 10; i++)
      cyc(0, 1, 0, 3'd0, 32'd0, $sformatf("run%0d", i), 64'(i), 64'd10, 0, 1);
    cyc(0, 1, 0, 3'd0, 32'd0, "run11_st", 64'd11, 64'd10, 1, 1);
    cyc(0, 1, 0, 3'd0, 32'd0, "run12_st", 64'd12, 64'd10, 1, 1);
    cyc(0, 0, 1, 3'd4, 32'd2, "clr_bit0_0", 64'd12, 64'd10, 1, 1);

    // Interrupt follows the enable when status is already set
    cyc(0, 0, 1, 3'd5, 32'd0, "en_off", 64'd12, 64'd10, 1, 0);
    cyc(0, 0, 1, 3'd5, 32'd1, "en_on",  64'd12, 64'd10, 1, 1);

    // Clear while the match persists has no effect; clear after moving does
    cyc(0, 0, 1, 3'd0, 32'd10, "park10",     64'd10, 64'd10, 1, 1);
    cyc(0, 0, 0, 3'd0, 32'd0,  "park_hold",  64'd10, 64'd10, 1, 1);
    cyc(0, 0, 1, 3'd4, 32'd1,  "clr_match",  64'd10, 64'd10, 1, 1);
    cyc(0, 1, 0, 3'd0, 32'd0,  "step11",     64'd11, 64'd10, 1, 1);
    cyc(0, 0, 1, 3'd4, 32'd1,  "clr_moved",  64'd11, 64'd10, 0, 1);

    // A counter write beats a coincident pulse; the other half is kept
    cyc(0, 0, 1, 3'd1, 32'd7,   "wr_hi7",     64'h0000_0007_0000_000B, 64'd10, 0, 1);
    cyc(0, 1, 1, 3'd0, 32'd100, "wr_lo100",   64'h0000_0007_0000_0064, 64'd10, 0, 1);
    cyc(0, 0, 1, 3'd3, 32'd3,   "cmp_hi3",    64'h0000_0007_0000_0064, 64'h0000_0003_0000_000A, 0, 1);

    // Reset while status is set and count = 123
    cyc(0, 0, 1, 3'd1, 32'd0,   "wr_hi0b",    64'd100, 64'h0000_0003_0000_000A, 0, 1);
    cyc(0, 0, 1, 3'd0, 32'd123, "wr_lo123",   64'd123, 64'h0000_0003_0000_000A, 0, 1);
    cyc(0, 0, 1, 3'd2, 32'd123, "cmp_lo123",  64'd123, 64'h0000_0003_0000_007B, 0, 1);
    cyc(0, 0, 1, 3'd3, 32'd0,   "cmp_hi0b",   64'd123, 64'd123, 0, 1);
    cyc(0, 0, 0, 3'd0, 32'd0,   "st123",      64'd123, 64'd123, 1, 1);
    cyc(1, 1, 1, 3'd5, 32'd1,   "reset_mid",  64'd0, ONES, 0, 0);
    cyc(0, 0, 0, 3'd0, 32'd0,   "post_reset", 64'd0, ONES, 0, 0);

    @(negedge clk);
    #1;
    check("drain", "pending", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
